// File: rtl/regfile.sv
// RV32I integer register file: x1..x31 in flops, x0 hardwired to zero.
// Two combinational operand read ports, one write port, one debug read port.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_rs1_addr,
   input  logic [ADDR_W-1:0] i_rs2_addr,
   output logic [DATA_W-1:0] o_rs1_data,
   output logic [DATA_W-1:0] o_rs2_data,
   input  logic              i_rd_wren,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [1:DEPTH-1];
   logic              wr_live;

   // A write only takes effect (and is only forwarded) outside reset and away from x0.
   assign wr_live = i_rst_n && i_rd_wren && (i_rd_addr != '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         regs <= '{default: '0};
      end else if (wr_live) begin
         regs[i_rd_addr] <= i_rd_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                   input logic             fwd_en);
      logic [DATA_W-1:0] val;
      val = '0;
      if (addr != '0) begin
         if (fwd_en && wr_live && (addr == i_rd_addr))
            val = i_rd_data;
         else
            val = regs[addr];
      end
      return val;
   endfunction

   always_comb begin
      o_rs1_data = read_port(i_rs1_addr, BYPASS != 0);
      o_rs2_data = read_port(i_rs2_addr, BYPASS != 0);
      o_dbg_data = read_port(i_dbg_addr, 1'b0);
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic,
// checked against an array model, on one bypassing and one non-bypassing instance.
module tb_regfile;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
   logic        rd_wren;
   logic [31:0] rd_data;
   logic [31:0] rs1_b, rs2_b, dbg_b;
   logic [31:0] rs1_n, rs2_n, dbg_n;

   int unsigned n_checks;
   int unsigned n_pass;
   logic [31:0] model [32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(rs1_b), .o_rs2_data(rs2_b),
      .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
      .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b)
   );

   regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(rs1_n), .o_rs2_data(rs2_n),
      .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
      .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
   endtask

   // Expected read: x0 is zero; a live write to the same index wins when forwarding.
   function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit fwd);
      if (a == 0) return 32'h0;
      if (fwd && rst_n && rd_wren && rd_addr != 0 && a == rd_addr) return rd_data;
      return model[a];
   endfunction

   task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] ad);
      rst_n = r; rd_wren = we; rd_addr = wa; rd_data = wd;
      rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
   endtask

   task automatic model_check();
      check("rs1_byp",   rs1_b, expect_rd(rs1_addr, 1'b1));
      check("rs2_byp",   rs2_b, expect_rd(rs2_addr, 1'b1));
      check("dbg_byp",   dbg_b, expect_rd(dbg_addr, 1'b0));
      check("rs1_nobyp", rs1_n, expect_rd(rs1_addr, 1'b0));
      check("rs2_nobyp", rs2_n, expect_rd(rs2_addr, 1'b0));
      check("dbg_nobyp", dbg_n, expect_rd(dbg_addr, 1'b0));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (rd_wren && rd_addr != 0) begin
         model[rd_addr] = rd_data;
      end
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // First reset: outputs are undefined before it, so nothing is checked.
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      @(posedge clk); #1;
      tick();

      // Reset clears a previously written register and all of x1..x31.
      set_in(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
      @(negedge clk); model_check(); tick();
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
      @(negedge clk); check("x5_written", rs1_b, 32'hDEADBEEF); tick();
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
      @(negedge clk); model_check(); tick();
      for (int i = 1; i < 32; i++) begin
         set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'(i));
         @(negedge clk);
         check("rst_rs1_x5", rs1_b, 32'h0);
         check("rst_dbg", dbg_b, 32'h0);
         tick();
      end

      // Writes to x0 never become visible.
      set_in(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("x0_rs1_same", rs1_b, 32'h0);
      check("x0_rs2_same", rs2_b, 32'h0);
      check("x0_dbg_same", dbg_b, 32'h0);
      tick();
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("x0_rs1_next", rs1_b, 32'h0);
      check("x0_rs2_next", rs2_b, 32'h0);
      check("x0_dbg_next", dbg_b, 32'h0);
      tick();

      // Extreme indices with extreme values.
      set_in(1'b1, 1'b1, 5'd1, 32'h00000001, 5'd0, 5'd0, 5'd0); tick();
      set_in(1'b1, 1'b1, 5'd31, 32'h80000000, 5'd0, 5'd0, 5'd0); tick();
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd31);
      @(negedge clk);
      check("wr_x1", rs1_b, 32'h00000001);
      check("wr_x31", rs2_b, 32'h80000000);
      check("wr_x31_dbg", dbg_b, 32'h80000000);
      check("srl31", rs2_b >> 31, 32'h00000001);
      tick();

      // Same-cycle forwarding vs stored value.
      set_in(1'b1, 1'b1, 5'd7, 32'hAAAA0000, 5'd0, 5'd0, 5'd0); tick();
      set_in(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7);
      @(negedge clk);
      check("byp_rs1", rs1_b, 32'h12345678);
      check("byp_rs2", rs2_b, 32'h12345678);
      check("byp_dbg", dbg_b, 32'hAAAA0000);
      check("nobyp_rs1", rs1_n, 32'hAAAA0000);
      check("nobyp_rs2", rs2_n, 32'hAAAA0000);
      tick();
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
      @(negedge clk);
      check("x7_after", rs1_b, 32'h12345678);
      check("x7_after_nb", rs2_n, 32'h12345678);
      tick();

      // Reset beats a simultaneous write, and suppresses forwarding.
      set_in(1'b1, 1'b1, 5'd9, 32'h00000011, 5'd0, 5'd0, 5'd0); tick();
      set_in(1'b0, 1'b1, 5'd9, 32'h00000055, 5'd9, 5'd9, 5'd9);
      @(negedge clk);
      check("rstwr_rs1", rs1_b, 32'h00000011);
      check("rstwr_rs2", rs2_b, 32'h00000011);
      tick();
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 5'd9);
      @(negedge clk);
      check("rstwr_x9", rs1_b, 32'h0);
      check("rstwr_x7", rs2_b, 32'h0);
      check("rstwr_dbg", dbg_b, 32'h0);
      tick();

      // Random traffic; read addresses often collide with the write address.
      for (int c = 0; c < 10000; c++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(0, 31));
         set_in(($urandom_range(0, 63) != 0),
                1'($urandom_range(0, 1)),
                wa,
                $urandom(),
                ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         @(negedge clk);
         model_check();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
